// File: rtl/br_pkg.sv
// br_pkg: shared widths, requester indices and write-command type
// for the register-bank write arbiter.
package br_pkg;

   localparam int AW = 5;
   localparam int DW = 32;

   localparam int REQ_ALU = 0;
   localparam int REQ_LD  = 1;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with one-hot grant.
// Under contention the requester other than `last` wins.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = 2'b00;
      priority case (1'b1)
         (req[0] && req[1]): gnt = last ? 2'b01 : 2'b10;
         req[0]:             gnt = 2'b01;
         req[1]:             gnt = 2'b10;
         default:            gnt = 2'b00;
      endcase
   end

   // Reset to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/br_write_arbiter.sv
// br_write_arbiter: arbitrates ALU/load writebacks into one bank write port
// and tracks pending writes. Macro BR_BYPASS_EN adds write-cycle bypass ports.
module br_write_arbiter
   import br_pkg::*;
#(
   parameter int AW = br_pkg::AW,
   parameter int DW = br_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          v0,
   input  logic [AW-1:0] a0,
   input  logic [DW-1:0] d0,
   input  logic          v1,
   input  logic [AW-1:0] a1,
   input  logic [DW-1:0] d1,
   output logic          rdy0,
   output logic          rdy1,
   input  logic          rsv_v,
   input  logic [AW-1:0] rsv_a,
   input  logic [AW-1:0] DL1,
   input  logic [AW-1:0] DL2,
   output logic          haz1,
   output logic          haz2,
`ifdef BR_BYPASS_EN
   output logic          byp1_hit,
   output logic [DW-1:0] byp1_dat,
   output logic          byp2_hit,
   output logic [DW-1:0] byp2_dat,
`endif
   output logic          WE,
   output logic [AW-1:0] DE,
   output logic [DW-1:0] Dato
);

   localparam int NREG = 1 << AW;

   logic [1:0]      gnt;
   logic            xfer;
   logic [AW-1:0]   wa;
   logic [DW-1:0]   wd;
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pend_nx;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({v1, v0}),
      .gnt   (gnt)
   );

   assign rdy0 = gnt[REQ_ALU];
   assign rdy1 = gnt[REQ_LD];
   assign xfer = |gnt;
   assign wa   = gnt[REQ_LD] ? a1 : a0;
   assign wd   = gnt[REQ_LD] ? d1 : d0;

   // Set after clear: a same-cycle reserve keeps the bit pending.
   always_comb begin
      pend_nx = pending;
      if (xfer) begin
         pend_nx[wa] = 1'b0;
      end
      if (rsv_v) begin
         pend_nx[rsv_a] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WE      <= 1'b0;
         DE      <= '0;
         Dato    <= '0;
         pending <= '0;
      end else begin
         WE      <= xfer;
         pending <= pend_nx;
         if (xfer) begin
            DE   <= wa;
            Dato <= wd;
         end
      end
   end

   assign haz1 = pending[DL1];
   assign haz2 = pending[DL2];

`ifdef BR_BYPASS_EN
   assign byp1_hit = WE && (DE == DL1);
   assign byp1_dat = Dato;
   assign byp2_hit = WE && (DE == DL2);
   assign byp2_dat = Dato;
`endif

endmodule

// File: tb/tb_br_write_arbiter.sv
// tb_br_write_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbiter/scoreboard model.
module tb_br_write_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          v0, v1, rsv_v;
   logic [AW-1:0] a0, a1, rsv_a, DL1, DL2;
   logic [DW-1:0] d0, d1;
   logic          rdy0, rdy1, haz1, haz2, WE;
   logic [AW-1:0] DE;
   logic [DW-1:0] Dato;
`ifdef BR_BYPASS_EN
   logic          byp1_hit, byp2_hit;
   logic [DW-1:0] byp1_dat, byp2_dat;
`endif

   int tests;
   int fails;

   br_write_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .v0       (v0),
      .a0       (a0),
      .d0       (d0),
      .v1       (v1),
      .a1       (a1),
      .d1       (d1),
      .rdy0     (rdy0),
      .rdy1     (rdy1),
      .rsv_v    (rsv_v),
      .rsv_a    (rsv_a),
      .DL1      (DL1),
      .DL2      (DL2),
      .haz1     (haz1),
      .haz2     (haz2),
`ifdef BR_BYPASS_EN
      .byp1_hit (byp1_hit),
      .byp1_dat (byp1_dat),
      .byp2_hit (byp2_hit),
      .byp2_dat (byp2_dat),
`endif
      .WE       (WE),
      .DE       (DE),
      .Dato     (Dato)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      v0 = 0; a0 = '0; d0 = '0;
      v1 = 0; a1 = '0; d1 = '0;
      rsv_v = 0; rsv_a = '0;
      DL1 = '0; DL2 = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      clear_inputs();
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      #3;
      tests++;
      if (WE !== 1'b0) begin
         fails++;
         $display("FAIL reset_we: got %b expected 0", WE);
      end
      tests++;
      if (DE !== '0 || Dato !== '0) begin
         fails++;
         $display("FAIL reset_port: got DE=%0h Dato=%0h expected 0/0",
                  DE, Dato);
      end
      for (int i = 0; i < 32; i++) begin
         DL1 = i[AW-1:0];
         DL2 = i[AW-1:0];
         #1;
         tests++;
         if (haz1 !== 1'b0 || haz2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_haz r%0d: got %b%b expected 00",
                     i, haz1, haz2);
         end
      end
      @(negedge clk);
      rst_n = 1;
      clear_inputs();
      tick();
   endtask

   task automatic test_single();
      do_reset();
      v0 = 1; a0 = 5; d0 = 32'hAAAA0000;
      #1;
      tests++;
      if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
         fails++;
         $display("FAIL single_rdy: got %b%b expected rdy0=1 rdy1=0",
                  rdy0, rdy1);
      end
      tick();
      v0 = 0;
      tests++;
      if (WE !== 1'b1 || DE !== 5 || Dato !== 32'hAAAA0000) begin
         fails++;
         $display("FAIL single_wr: got WE=%b DE=%0d D=%h expected 1/5/aaaa0000",
                  WE, DE, Dato);
      end
      tick();
      tests++;
      if (WE !== 1'b0 || DE !== 5 || Dato !== 32'hAAAA0000) begin
         fails++;
         $display("FAIL single_hold: got WE=%b DE=%0d D=%h expected 0/5/aaaa0000",
                  WE, DE, Dato);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g;
      do_reset();
      v0 = 1; a0 = 1; d0 = 32'h0000_0A00;
      v1 = 1; a1 = 2; d1 = 32'h0000_0B00;
      for (int i = 0; i < 4; i++) begin
         #1;
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         tests++;
         if ({rdy1, rdy0} !== exp_g) begin
            fails++;
            $display("FAIL b2b_grant%0d: got %b expected %b",
                     i, {rdy1, rdy0}, exp_g);
         end
         tick();
         tests++;
         if (WE !== 1'b1 || DE !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
            fails++;
            $display("FAIL b2b_we%0d: got WE=%b DE=%0d expected 1/%0d",
                     i, WE, DE, (i % 2 == 0) ? 1 : 2);
         end
      end
      clear_inputs();
   endtask

   task automatic test_hazard();
      do_reset();
      rsv_v = 1; rsv_a = 7;
      tick();
      rsv_v = 0;
      DL1 = 7;
      #1;
      tests++;
      if (haz1 !== 1'b1) begin
         fails++;
         $display("FAIL haz_set: got %b expected 1", haz1);
      end
      v1 = 1; a1 = 7; d1 = 32'h0000_7777;
      #1;
      tests++;
      if (rdy1 !== 1'b1 || haz1 !== 1'b1) begin
         fails++;
         $display("FAIL haz_grant: got rdy1=%b haz1=%b expected 1/1",
                  rdy1, haz1);
      end
      tick();
      v1 = 0;
      tests++;
      if (haz1 !== 1'b0 || WE !== 1'b1 || DE !== 7) begin
         fails++;
         $display("FAIL haz_clr: got haz1=%b WE=%b DE=%0d expected 0/1/7",
                  haz1, WE, DE);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      rsv_v = 1; rsv_a = 9;
      tick();
      v0 = 1; a0 = 9; d0 = 32'h0000_0909;
      DL2 = 9;
      #1;
      tests++;
      if (rdy0 !== 1'b1) begin
         fails++;
         $display("FAIL same_rdy: got %b expected 1", rdy0);
      end
      tick();
      clear_inputs();
      DL2 = 9;
      #1;
      tests++;
      if (haz2 !== 1'b1 || WE !== 1'b1 || DE !== 9) begin
         fails++;
         $display("FAIL same_pend: got haz2=%b WE=%b DE=%0d expected 1/1/9",
                  haz2, WE, DE);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      v0 = 1; a0 = 3; d0 = 32'h0000_0333;
      rsv_v = 1; rsv_a = 4;
      tick();
      clear_inputs();
      DL1 = 4;
      #1;
      tests++;
      if (WE !== 1'b1 || DE !== 3 || haz1 !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre: got WE=%b DE=%0d haz1=%b expected 1/3/1",
                  WE, DE, haz1);
      end
      rst_n = 0;
      #1;
      tests++;
      if (WE !== 0 || DE !== 0 || Dato !== 0 || haz1 !== 0) begin
         fails++;
         $display("FAIL mid_async: got WE=%b DE=%0d D=%h haz1=%b expected 0/0/0/0",
                  WE, DE, Dato, haz1);
      end
      @(negedge clk);
      rst_n = 1;
      tick();
      tests++;
      if (WE !== 1'b0) begin
         fails++;
         $display("FAIL mid_nopulse: got %b expected 0", WE);
      end
      v0 = 1; v1 = 1; a0 = 6; a1 = 8;
      #1;
      tests++;
      if ({rdy1, rdy0} !== 2'b01) begin
         fails++;
         $display("FAIL mid_first: got %b expected 01", {rdy1, rdy0});
      end
      tick();
      clear_inputs();
   endtask

`ifdef BR_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      v0 = 1; a0 = 12; d0 = 32'h0000_1234;
      tick();
      v0 = 0;
      DL2 = 12;
      #1;
      tests++;
      if (byp2_hit !== 1'b1 || byp2_dat !== 32'h1234) begin
         fails++;
         $display("FAIL byp_hit: got %b/%h expected 1/1234",
                  byp2_hit, byp2_dat);
      end
      tick();
      tests++;
      if (byp2_hit !== 1'b0) begin
         fails++;
         $display("FAIL byp_drop: got %b expected 0", byp2_hit);
      end
   endtask
`endif

   // Model: a set of pending register numbers, the index of the
   // most recent winner, and the last write issued to the bank.
   task automatic test_random();
      bit            pend [32];
      int            last_w;
      int            g;
      logic          e_we;
      logic [AW-1:0] e_de;
      logic [DW-1:0] e_dat;
      logic [1:0]    e_rdy;
      do_reset();
      foreach (pend[k]) pend[k] = 0;
      last_w = 1;
      e_we = 0; e_de = '0; e_dat = '0;
      g = -1;
      for (int c = 0; c < 400; c++) begin
         if (!v0 || g == 0 || $urandom_range(0, 9) == 0) begin
            v0 = ($urandom_range(0, 3) != 0);
            a0 = AW'($urandom_range(0, 31));
            d0 = $urandom;
         end
         if (!v1 || g == 1 || $urandom_range(0, 9) == 0) begin
            v1 = ($urandom_range(0, 2) != 0);
            a1 = AW'($urandom_range(0, 31));
            d1 = $urandom;
         end
         rsv_v = $urandom_range(0, 1);
         rsv_a = AW'($urandom_range(0, 31));
         DL1 = AW'($urandom_range(0, 31));
         DL2 = AW'($urandom_range(0, 31));
         #1;
         if (v0 && v1) g = (last_w == 0) ? 1 : 0;
         else if (v0) g = 0;
         else if (v1) g = 1;
         else g = -1;
         e_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
         tests++;
         if ({rdy1, rdy0} !== e_rdy) begin
            fails++;
            $display("FAIL rnd_rdy c%0d: got %b expected %b",
                     c, {rdy1, rdy0}, e_rdy);
         end
         tests++;
         if (haz1 !== pend[DL1] || haz2 !== pend[DL2]) begin
            fails++;
            $display("FAIL rnd_haz c%0d: got %b%b expected %b%b",
                     c, haz1, haz2, pend[DL1], pend[DL2]);
         end
         tick();
         if (g >= 0) begin
            e_we  = 1;
            e_de  = (g == 0) ? a0 : a1;
            e_dat = (g == 0) ? d0 : d1;
            pend[e_de] = 0;
            last_w = g;
         end else begin
            e_we = 0;
         end
         if (rsv_v) pend[rsv_a] = 1;
         tests++;
         if (WE !== e_we || DE !== e_de || Dato !== e_dat) begin
            fails++;
            $display("FAIL rnd_wr c%0d: got %b/%0d/%h expected %b/%0d/%h",
                     c, WE, DE, Dato, e_we, e_de, e_dat);
         end
      end
      clear_inputs();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 0;
      clear_inputs();
      test_reset();
      test_single();
      test_back_to_back();
      test_hazard();
      test_same_cycle();
      test_reset_mid();
`ifdef BR_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/br_write_arbiter.md
BR_WRITE_ARBITER -- requirements
Module: br_write_arbiter

Interface
REQ-001 SHALL have parameter: AW, 5, register-address width (32 registers).
REQ-002 SHALL have parameter: DW, 32, register data width.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: v0 / a0 / d0  input  1 / AW / DW  requester 0 (ALU writeback) valid, address, data.
REQ-006 SHALL have ports: v1 / a1 / d1  input  1 / AW / DW  requester 1 (load unit) valid, address, data.
REQ-007 SHALL have ports: rdy0, rdy1  output  1  per-requester grant; transfer occurs when vN && rdyN.
REQ-008 SHALL have ports: rsv_v / rsv_a  input  1 / AW  reserve register rsv_a as pending-write.
REQ-009 SHALL have ports: DL1, DL2  input  AW  read addresses presented to the register bank.
REQ-010 SHALL have ports: haz1, haz2  output  1  read address is pending (hazard).
REQ-011 SHALL have ports: WE / DE / Dato  output  1 / AW / DW  registered write port to the register bank.

Function
REQ-012 SHALL make rdyN combinational: single valid -> that requester granted; both valid -> round-robin.
REQ-013 SHALL use round-robin pointer `last`: both valid grants requester != last; `last` updates to the granted index on each transfer.
REQ-014 SHALL register the granted transfer into WE=1, DE=aN, Dato=dN on the next edge; latency 1 cycle; no transfer -> WE=0, DE/Dato hold.
REQ-015 SHALL keep a 32-bit pending vector: rsv_v sets bit rsv_a; issued transfer clears bit aN.
REQ-016 SHALL give set priority when reserve and clear target the same address in one cycle (bit stays 1).
REQ-017 SHALL drive haz1 = pending[DL1], haz2 = pending[DL2], combinationally from registered state.
REQ-018 SHALL arbitrate both valid with equal addresses normally; the loser waits and writes on a later cycle (last-writer order = grant order).
REQ-019 SHALL accept a transfer every cycle (throughput 1 write/cycle), with no bubble between back-to-back grants.
REQ-020 SHALL require requesters to hold vN/aN/dN stable until rdyN; dropping vN before grant is allowed and cancels the request.

Reset
REQ-021 SHALL on rst_n=0 clear immediately: WE=0, DE=0, Dato=0, pending=0, last=1 (requester 0 wins first contention).
REQ-022 SHALL drop any in-flight registered write when reset asserts mid-operation; no WE pulse after release until a new transfer.

Configuration
REQ-023 SHALL, with BR_BYPASS_EN defined, add outputs byp1_hit/byp1_dat and byp2_hit/byp2_dat: hit = WE && DE==DLn, dat = Dato.
REQ-024 SHALL, without BR_BYPASS_EN, have no bypass ports or logic; consumers stall on haz until the bank write completes.

Structure
REQ-025 SHALL place AW, DW, requester-index constants (REQ_ALU=0, REQ_LD=1) and the write-command struct {we, addr, data} in shared package br_pkg.
REQ-026 SHALL implement arbitration as sub-module rr_arb2 (two requests, `last` pointer, one-hot grant); pending vector and output register stay in the top.

Verification
REQ-027 SHALL test: v0=1,a0=5,d0=0xAAAA0000 alone -> rdy0=1 same cycle; next edge WE=1, DE=5, Dato=0xAAAA0000.
REQ-028 SHALL test: v0,v1 held high 4 cycles after reset -> grants 0,1,0,1; WE high every cycle.
REQ-029 SHALL test: rsv_v=1,rsv_a=7 then DL1=7 -> haz1=1; load write a1=7 granted -> haz1=0 the cycle after the grant edge.
REQ-030 SHALL test: reserve r9 and grant write to r9 in the same cycle -> pending[9] remains 1, haz=1 with DL2=9.
REQ-031 SHALL test: rst_n low while WE=1, DE=3 -> WE=0, DE=0, pending=0 without a clock edge; after release, first contention grants requester 0.
REQ-032 SHALL test, with BR_BYPASS_EN: write r12=0x1234 issued, DL2=12 in the WE cycle -> byp2_hit=1, byp2_dat=0x1234; next cycle hit=0.
